// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with midpoint sampling.
// Reports framing errors and rejects start-bit glitches.
module uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Frame_Err,
  output logic       o_RX_Active
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            meta_q, meta_d;
  logic            rx_s_q, rx_s_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic            dv_q, dv_d;
  logic            ferr_q, ferr_d;
  logic            active_q, active_d;

  always_comb begin
    meta_d  = i_RX_Serial;
    rx_s_d  = meta_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    dv_d    = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s_q) state_d = S_START;
      end

      S_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            byte_d  = shift_q;
            dv_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // A held-low line (break) must not be decoded as more frames.
      S_WAIT_HIGH: begin
        cnt_d = '0;
        idx_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    active_d = (state_d == S_START) ||
               (state_d == S_DATA)  ||
               (state_d == S_STOP);
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      meta_q   <= 1'b1;
      rx_s_q   <= 1'b1;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      dv_q     <= 1'b0;
      ferr_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      meta_q   <= meta_d;
      rx_s_q   <= rx_s_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      dv_q     <= dv_d;
      ferr_q   <= ferr_d;
      active_q <= active_d;
    end
  end

  assign o_RX_DV        = dv_q;
  assign o_RX_Byte      = byte_q;
  assign o_RX_Frame_Err = ferr_q;
  assign o_RX_Active    = active_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives 8N1 frames (nominal and skewed baud)
// into uart_rx and compares against a byte-level model.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int H   = (CPB - 1) / 2;
  localparam int LAT = 4 + H + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       line;
  logic       dv;
  logic [7:0] rx_byte;
  logic       fe;
  logic       act;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock        (clk),
    .i_Rst_L        (rst_n),
    .i_RX_Serial    (line),
    .o_RX_DV        (dv),
    .o_RX_Byte      (rx_byte),
    .o_RX_Frame_Err (fe),
    .o_RX_Active    (act)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;
  int act_cnt = 0;
  int viol = 0;
  int last_dv_cyc = 0;
  logic prev_pulse = 1'b0;
  logic [7:0] rx_mem [0:255];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dv) begin
      rx_mem[dv_cnt[7:0]] <= rx_byte;
      dv_cnt <= dv_cnt + 1;
      last_dv_cyc <= cyc;
    end
    if (fe) fe_cnt <= fe_cnt + 1;
    if (act) act_cnt <= act_cnt + 1;
    if ((dv && fe) || ((dv || fe) && prev_pulse))
      viol <= viol + 1;
    prev_pulse <= dv || fe;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bit j of the frame ends floor((j+1)*p100/100) clocks after start.
  task automatic send_frame(input logic [7:0] b, input int p100,
                            input logic stop_bit, output int s);
    logic [9:0] fr;
    int t;
    int e;
    fr = {stop_bit, b, 1'b0};
    s = cyc;
    t = 0;
    for (int j = 0; j < 10; j++) begin
      line = fr[j];
      e = ((j + 1) * p100) / 100;
      wait_cyc(e - t);
      t = e;
    end
    line = 1'b1;
  endtask

  task automatic test_reset;
    line = 1'b1;
    rst_n = 1'b0;
    wait_cyc(5);
    tests++;
    if (dv !== 1'b0) begin
      fails++; $display("FAIL reset_dv: got %b want 0", dv);
    end
    tests++;
    if (fe !== 1'b0) begin
      fails++; $display("FAIL reset_fe: got %b want 0", fe);
    end
    tests++;
    if (act !== 1'b0) begin
      fails++; $display("FAIL reset_active: got %b want 0", act);
    end
    tests++;
    if (rx_byte !== 8'h00) begin
      fails++; $display("FAIL reset_byte: got %h want 00", rx_byte);
    end
    rst_n = 1'b1;
    wait_cyc(3);
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] b;
    logic [7:0] v;
    int s;
    int base;
    b = 8'($urandom);
    v = 8'($urandom);
    send_frame(b, 100 * CPB, 1'b1, s);
    wait_cyc(4);
    tests++;
    if (rx_byte !== b) begin
      fails++; $display("FAIL pre_reset_byte: got %h want %h", rx_byte, b);
    end
    base = dv_cnt;
    line = 1'b0;
    wait_cyc(CPB);
    for (int k = 0; k < 3; k++) begin
      line = v[k];
      wait_cyc(CPB);
    end
    line = v[3];
    wait_cyc(CPB / 2);
    tests++;
    if (act !== 1'b1) begin
      fails++; $display("FAIL mid_frame_active: got %b want 1", act);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({dv, fe, act} !== 3'b000) begin
      fails++; $display("FAIL async_reset_flags: got %b want 000", {dv, fe, act});
    end
    tests++;
    if (rx_byte !== 8'h00) begin
      fails++; $display("FAIL async_reset_byte: got %h want 00", rx_byte);
    end
    line = 1'b1;
    wait_cyc(3);
    #2 rst_n = 1'b1;
    wait_cyc(4);
    tests++;
    if (dv_cnt !== base) begin
      fails++; $display("FAIL aborted_frame_dv: got %0d want %0d", dv_cnt - base, 0);
    end
    send_frame(8'h5A, 100 * CPB, 1'b1, s);
    wait_cyc(4);
    tests++;
    if (dv_cnt - base !== 1 || rx_byte !== 8'h5A) begin
      fails++;
      $display("FAIL post_reset_frame: got %0d x %h want 1 x 5a", dv_cnt - base, rx_byte);
    end
  endtask

  task automatic test_loopback;
    logic [7:0] pats [6];
    int s;
    int base;
    pats[0] = 8'hA5;
    pats[1] = 8'h00;
    pats[2] = 8'hFF;
    for (int i = 3; i < 6; i++) pats[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) begin
      base = dv_cnt;
      send_frame(pats[i], 100 * CPB, 1'b1, s);
      wait_cyc(4);
      tests++;
      if (dv_cnt - base !== 1) begin
        fails++; $display("FAIL loop_dv_count[%0d]: got %0d want 1", i, dv_cnt - base);
      end
      tests++;
      if (rx_byte !== pats[i]) begin
        fails++; $display("FAIL loop_byte[%0d]: got %h want %h", i, rx_byte, pats[i]);
      end
      tests++;
      if (last_dv_cyc - s !== LAT) begin
        fails++;
        $display("FAIL loop_latency[%0d]: got %0d want %0d", i, last_dv_cyc - s, LAT);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] pats [5];
    int s;
    int base;
    int fbase;
    pats[0] = 8'h81;
    pats[1] = 8'h7E;
    pats[2] = 8'h3C;
    pats[3] = 8'($urandom);
    pats[4] = 8'($urandom);
    base = dv_cnt;
    fbase = fe_cnt;
    for (int i = 0; i < 5; i++) send_frame(pats[i], 100 * CPB, 1'b1, s);
    wait_cyc(4);
    tests++;
    if (dv_cnt - base !== 5) begin
      fails++; $display("FAIL b2b_dv_count: got %0d want 5", dv_cnt - base);
    end
    tests++;
    if (fe_cnt !== fbase) begin
      fails++; $display("FAIL b2b_frame_err: got %0d want 0", fe_cnt - fbase);
    end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (rx_mem[8'(base + i)] !== pats[i]) begin
        fails++;
        $display("FAIL b2b_byte[%0d]: got %h want %h", i, rx_mem[8'(base + i)], pats[i]);
      end
    end
  endtask

  task automatic test_glitch;
    logic [7:0] b;
    int s;
    int base;
    int fbase;
    int abase;
    base = dv_cnt;
    fbase = fe_cnt;
    abase = act_cnt;
    line = 1'b0;
    wait_cyc(4);
    line = 1'b1;
    wait_cyc(30);
    tests++;
    if (dv_cnt !== base || fe_cnt !== fbase) begin
      fails++;
      $display("FAIL glitch_pulses: got dv %0d fe %0d want 0 0", dv_cnt - base, fe_cnt - fbase);
    end
    tests++;
    if (act_cnt - abase !== H + 1) begin
      fails++; $display("FAIL glitch_active_len: got %0d want %0d", act_cnt - abase, H + 1);
    end
    tests++;
    if (act !== 1'b0) begin
      fails++; $display("FAIL glitch_idle: got active %b want 0", act);
    end
    b = 8'($urandom);
    send_frame(b, 100 * CPB, 1'b1, s);
    wait_cyc(4);
    tests++;
    if (dv_cnt - base !== 1 || rx_byte !== b) begin
      fails++;
      $display("FAIL after_glitch: got %0d x %h want 1 x %h", dv_cnt - base, rx_byte, b);
    end
  endtask

  task automatic test_frame_err;
    logic [7:0] prev;
    int s;
    int base;
    int fbase;
    prev = 8'($urandom);
    send_frame(prev, 100 * CPB, 1'b1, s);
    wait_cyc(4);
    base = dv_cnt;
    fbase = fe_cnt;
    send_frame(8'h3C, 100 * CPB, 1'b0, s);
    line = 1'b0;
    wait_cyc(40);
    tests++;
    if (fe_cnt - fbase !== 1) begin
      fails++; $display("FAIL ferr_count: got %0d want 1", fe_cnt - fbase);
    end
    tests++;
    if (dv_cnt !== base) begin
      fails++; $display("FAIL ferr_no_dv: got %0d want 0", dv_cnt - base);
    end
    tests++;
    if (rx_byte !== prev) begin
      fails++; $display("FAIL ferr_byte_held: got %h want %h", rx_byte, prev);
    end
    tests++;
    if (act !== 1'b0) begin
      fails++; $display("FAIL ferr_break_active: got %b want 0", act);
    end
    line = 1'b1;
    wait_cyc(5);
    send_frame(8'hC3, 100 * CPB, 1'b1, s);
    wait_cyc(4);
    tests++;
    if (dv_cnt - base !== 1 || rx_byte !== 8'hC3 || fe_cnt - fbase !== 1) begin
      fails++;
      $display("FAIL after_break: got %0d x %h fe %0d want 1 x c3 fe 1",
               dv_cnt - base, rx_byte, fe_cnt - fbase);
    end
  endtask

  // Transmitter running 3% slow and 3% fast.
  task automatic test_skew;
    int periods [2];
    logic [7:0] b;
    int s;
    int base;
    periods[0] = 97 * CPB;
    periods[1] = 103 * CPB;
    for (int p = 0; p < 2; p++) begin
      for (int r = 0; r < 3; r++) begin
        b = (r == 0) ? 8'h55 : 8'($urandom);
        base = dv_cnt;
        send_frame(b, periods[p], 1'b1, s);
        wait_cyc(4);
        tests++;
        if (dv_cnt - base !== 1 || rx_byte !== b) begin
          fails++;
          $display("FAIL skew_p%0d_r%0d: got %0d x %h want 1 x %h",
                   periods[p], r, dv_cnt - base, rx_byte, b);
        end
      end
    end
  endtask

  task automatic test_pulse_rules;
    tests++;
    if (viol !== 0) begin
      fails++; $display("FAIL pulse_exclusive: got %0d violations want 0", viol);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    line = 1'b1;
    test_reset;
    test_reset_mid_frame;
    test_loopback;
    test_back_to_back;
    test_glitch;
    test_frame_err;
    test_skew;
    test_pulse_rules;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
